// File: rtl/inst_prefetch_buffer.sv
// Next-line instruction prefetch stage sitting between the instruction cache's
// line-fill port and the memory arbiter. Line fills are served from a single
// buffered line when it matches, otherwise they are forwarded to memory.
// Prefetch hints fill the buffer in the background when the stage is idle.
module inst_prefetch_buffer #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int cnt_w    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cache_pmem_address,
    input  logic              cache_pmem_read,
    output logic [s_line-1:0] cache_pmem_rdata,
    output logic              cache_pmem_resp,
    output logic [31:0]       fetched_address,
    input  logic              prefetch,
    input  logic [31:0]       prefetch_address,
    output logic              prefetch_ready,
    output logic [31:0]       mem_address,
    output logic              mem_read,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [cnt_w-1:0]  pf_hit_count,
    output logic [cnt_w-1:0]  pf_issue_count
);

    localparam int TAG_W = 32 - s_offset;

    typedef enum logic [2:0] {
        IDLE,
        HIT_RESP,
        DEMAND,
        PREFETCH,
        DONE
    } state_t;

    state_t            state_reg;
    logic [31:0]       base_reg;
    logic              buf_valid_reg;
    logic [TAG_W-1:0]  buf_tag_reg;
    logic [s_line-1:0] buf_data_reg;
    logic [s_line-1:0] rdata_reg;
    logic [31:0]       fetched_reg;
    logic [cnt_w-1:0]  hit_cnt_reg;
    logic [cnt_w-1:0]  issue_cnt_reg;

    logic [31:0]       demand_base;
    logic [31:0]       prefetch_base;
    logic [31:0]       buf_base;
    logic              demand_hit;
    logic              pf_buffered;
    logic              resp_hit;
    logic              resp_mem;

    // Byte-offset bits never influence which line is fetched.
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, cache_pmem_address[s_offset-1:0],
                                  prefetch_address[s_offset-1:0]};

    assign demand_base   = {cache_pmem_address[31:s_offset], {s_offset{1'b0}}};
    assign prefetch_base = {prefetch_address[31:s_offset], {s_offset{1'b0}}};
    assign buf_base      = {buf_tag_reg, {s_offset{1'b0}}};
    assign demand_hit    = buf_valid_reg && (cache_pmem_address[31:s_offset] == buf_tag_reg);
    assign pf_buffered   = buf_valid_reg && (prefetch_address[31:s_offset] == buf_tag_reg);

    // A hint is only taken when idle and no demand competes for this cycle.
    assign prefetch_ready = (state_reg == IDLE) && !cache_pmem_read;

    // The demand response is combinational with mem_resp so a miss returns in
    // the same cycle memory answers; outside a response the last line is held.
    assign resp_hit         = (state_reg == HIT_RESP);
    assign resp_mem         = (state_reg == DEMAND) && mem_resp;
    assign cache_pmem_resp  = resp_hit || resp_mem;
    assign cache_pmem_rdata = resp_hit ? buf_data_reg : (resp_mem ? mem_rdata : rdata_reg);
    assign fetched_address  = resp_hit ? buf_base : (resp_mem ? base_reg : fetched_reg);

    assign mem_read       = (state_reg == DEMAND) || (state_reg == PREFETCH);
    assign mem_address    = base_reg;
    assign pf_hit_count   = hit_cnt_reg;
    assign pf_issue_count = issue_cnt_reg;

    // Control FSM, buffer tag/valid, held response values and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            rdata_reg     <= '0;
            fetched_reg   <= '0;
            hit_cnt_reg   <= '0;
            issue_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cache_pmem_read) begin
                        if (demand_hit) begin
                            state_reg <= HIT_RESP;
                        end else begin
                            base_reg  <= demand_base;
                            state_reg <= DEMAND;
                        end
                    end else if (prefetch && !pf_buffered) begin
                        base_reg  <= prefetch_base;
                        state_reg <= PREFETCH;
                        if (issue_cnt_reg != {cnt_w{1'b1}}) begin
                            issue_cnt_reg <= issue_cnt_reg + 1'b1;
                        end
                    end
                end
                HIT_RESP: begin
                    rdata_reg   <= buf_data_reg;
                    fetched_reg <= buf_base;
                    if (hit_cnt_reg != {cnt_w{1'b1}}) begin
                        hit_cnt_reg <= hit_cnt_reg + 1'b1;
                    end
                    state_reg <= DONE;
                end
                DEMAND: begin
                    if (mem_resp) begin
                        rdata_reg   <= mem_rdata;
                        fetched_reg <= base_reg;
                        state_reg   <= DONE;
                    end
                end
                PREFETCH: begin
                    if (mem_resp) begin
                        buf_tag_reg   <= base_reg[31:s_offset];
                        buf_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                DONE: begin
                    // Swallows the cycle in which the cache is still dropping its request.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Buffered line data; only meaningful while buf_valid_reg is set.
    always_ff @(posedge clk) begin
        if ((state_reg == PREFETCH) && mem_resp) begin
            buf_data_reg <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
module tb_inst_prefetch_buffer;

    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    cache_pmem_address;
    logic           cache_pmem_read;
    logic [255:0]   cache_pmem_rdata;
    logic           cache_pmem_resp;
    logic [31:0]    fetched_address;
    logic           prefetch;
    logic [31:0]    prefetch_address;
    logic           prefetch_ready;
    logic [31:0]    mem_address;
    logic           mem_read;
    logic [255:0]   mem_rdata;
    logic           mem_resp;
    logic [CW-1:0]  pf_hit_count;
    logic [CW-1:0]  pf_issue_count;

    always #5 clk = ~clk;

    inst_prefetch_buffer #(.s_offset(5), .s_line(256), .cnt_w(CW)) dut (
        .clk(clk),
        .rst(rst),
        .cache_pmem_address(cache_pmem_address),
        .cache_pmem_read(cache_pmem_read),
        .cache_pmem_rdata(cache_pmem_rdata),
        .cache_pmem_resp(cache_pmem_resp),
        .fetched_address(fetched_address),
        .prefetch(prefetch),
        .prefetch_address(prefetch_address),
        .prefetch_ready(prefetch_ready),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp),
        .pf_hit_count(pf_hit_count),
        .pf_issue_count(pf_issue_count)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mem_txn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    // Memory model: answers each read 4 cycles after it appears.
    function automatic logic [255:0] mem_pattern(input logic [31:0] a);
        if (a == 32'h1000_0040) return {32{8'hA5}};
        return {8{a}};
    endfunction

    initial begin
        int lat;
        lat = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mem_resp = 1'b0;
                lat = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (mem_read) begin
                lat++;
                if (lat == 4) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_pattern(mem_address);
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Count completed memory transactions.
    always @(posedge clk) begin
        if (rst && mem_read && mem_resp) mem_txn <= mem_txn + 1;
    end

    // Scoreboard monitor: every fill response is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && cache_pmem_resp === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp: got addr %h expected no response", fetched_address);
                end else begin
                    e = sb.pop_front();
                    if (fetched_address !== e.addr || cache_pmem_rdata !== e.data) begin
                        bad++;
                        $display("FAIL resp: got addr %h data %h expected addr %h data %h",
                                 fetched_address, cache_pmem_rdata, e.addr, e.data);
                    end else begin
                        $display("resp addr=%h data=%h ok", fetched_address, cache_pmem_rdata[31:0]);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [255:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Demand fill: raise read, wait for resp (bounded), drop read after the resp edge.
    task automatic demand(input logic [31:0] a, output int lat, output logic [31:0] seen_ma);
        cache_pmem_address = a;
        cache_pmem_read = 1'b1;
        lat = 0;
        seen_ma = '0;
        forever begin
            @(negedge clk);
            if (mem_read) seen_ma = mem_address;
            if (cache_pmem_resp) break;
            lat++;
            if (lat >= 40) begin
                total++;
                bad++;
                $display("FAIL demand_timeout: got no resp expected resp for %h", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        cache_pmem_read = 1'b0;
    endtask

    task automatic prefetch_hint(input logic [31:0] a, input logic exp_ready);
        prefetch_address = a;
        prefetch = 1'b1;
        @(negedge clk);
        check("prefetch_ready_on_hint", {31'b0, prefetch_ready}, {31'b0, exp_ready});
        @(posedge clk);
        #1;
        prefetch = 1'b0;
    endtask

    task automatic wait_mem_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_read) break;
            n++;
            if (n >= 40) begin
                total++;
                bad++;
                $display("FAIL fill_timeout: got mem_read 1 expected 0");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_resp"}, {31'b0, cache_pmem_resp}, 32'h0);
        check({tag, "_mem_read"}, {31'b0, mem_read}, 32'h0);
        check({tag, "_mem_address"}, mem_address, 32'h0);
        check({tag, "_fetched"}, fetched_address, 32'h0);
        check({tag, "_rdata_nonzero"}, {31'b0, |cache_pmem_rdata}, 32'h0);
        check({tag, "_hit_count"}, {30'b0, pf_hit_count}, 32'h0);
        check({tag, "_issue_count"}, {30'b0, pf_issue_count}, 32'h0);
    endtask

    initial begin
        int lat;
        int txn0;
        logic [31:0] seen_ma;

        rst = 1'b0;
        cache_pmem_address = '0;
        cache_pmem_read = 1'b0;
        prefetch = 1'b0;
        prefetch_address = '0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_zero_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("por_release_ready", {31'b0, prefetch_ready}, 32'h1);
        check("por_release_mem_read", {31'b0, mem_read}, 32'h0);
        @(posedge clk);
        #1;

        // Demand miss forwarded to memory.
        txn0 = mem_txn;
        push_exp(32'h1000_0040, {32{8'hA5}});
        demand(32'h1000_0044, lat, seen_ma);
        check("miss_mem_address", seen_ma, 32'h1000_0040);
        check("miss_mem_txn", mem_txn - txn0, 32'd1);
        @(negedge clk);
        check("done_ready", {31'b0, prefetch_ready}, 32'h0);
        @(negedge clk);
        check("fetched_hold", fetched_address, 32'h1000_0040);
        check("resp_idle_low", {31'b0, cache_pmem_resp}, 32'h0);
        @(posedge clk);
        #1;

        // Prefetch fills the buffer, then a same-line demand hits it.
        txn0 = mem_txn;
        prefetch_hint(32'h1000_0060, 1'b1);
        wait_mem_idle();
        check("pf_fill_txn", mem_txn - txn0, 32'd1);
        check("pf_issue_1", {30'b0, pf_issue_count}, 32'd1);
        txn0 = mem_txn;
        push_exp(32'h1000_0060, {8{32'h1000_0060}});
        demand(32'h1000_0064, lat, seen_ma);
        check("hit_latency", lat, 32'd1);
        check("hit_no_mem", mem_txn - txn0, 32'd0);
        check("hit_count_1", {30'b0, pf_hit_count}, 32'd1);

        // Reset in the middle of a demand miss.
        to_idle();
        cache_pmem_address = 32'h0000_5000;
        cache_pmem_read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_mem_read", {31'b0, mem_read}, 32'h1);
        rst = 1'b0;
        cache_pmem_read = 1'b0;
        #1;
        check("async_mem_read_drop", {31'b0, mem_read}, 32'h0);
        repeat (3) @(negedge clk);
        check_zero_outputs("mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_release_ready", {31'b0, prefetch_ready}, 32'h1);
        check("mid_release_mem_read", {31'b0, mem_read}, 32'h0);
        @(posedge clk);
        #1;

        // Demand to the line being prefetched waits and is served from the buffer.
        txn0 = mem_txn;
        prefetch_hint(32'h1000_0080, 1'b1);
        push_exp(32'h1000_0080, {8{32'h1000_0080}});
        demand(32'h1000_0080, lat, seen_ma);
        check("inflight_mem_address", seen_ma, 32'h1000_0080);
        check("inflight_one_txn", mem_txn - txn0, 32'd1);
        check("inflight_hit_count", {30'b0, pf_hit_count}, 32'd1);
        check("inflight_issue_count", {30'b0, pf_issue_count}, 32'd1);

        // Same-cycle demand and prefetch: demand wins, hint refused.
        to_idle();
        txn0 = mem_txn;
        prefetch_address = 32'h0000_2000;
        prefetch = 1'b1;
        cache_pmem_address = 32'h0000_3000;
        cache_pmem_read = 1'b1;
        @(negedge clk);
        check("conflict_ready", {31'b0, prefetch_ready}, 32'h0);
        @(posedge clk);
        #1;
        prefetch = 1'b0;
        push_exp(32'h0000_3000, {8{32'h0000_3000}});
        demand(32'h0000_3000, lat, seen_ma);
        check("conflict_mem_address", seen_ma, 32'h0000_3000);
        check("conflict_one_txn", mem_txn - txn0, 32'd1);
        check("conflict_issue_count", {30'b0, pf_issue_count}, 32'd1);

        // Repeated buffer hits saturate the 2-bit hit counter at 3.
        for (int k = 1; k <= 5; k++) begin
            to_idle();
            push_exp(32'h1000_0080, {8{32'h1000_0080}});
            demand(32'h1000_009C, lat, seen_ma);
            check("sat_hit_latency", lat, 32'd1);
            check("sat_hit_count", {30'b0, pf_hit_count}, (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Next-line instruction prefetch stage between inst_cache's physical-memory port and the memory arbiter.
- Serves cache line fills, either from a one-line prefetch buffer or by forwarding to memory.
- Accepts prefetch hints from inst_cache and reports the address of each returned line on fetched_address.

Parameters:
s_offset, 5, byte-offset bits per line; line base = address with low s_offset bits cleared
s_line, 256, line width in bits
cnt_w, 16, width of the saturating performance counters

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
cache_pmem_address  input  32  line-fill address from inst_cache
cache_pmem_read  input  1  fill request; held high until cache_pmem_resp
cache_pmem_rdata  output  s_line  line returned to inst_cache
cache_pmem_resp  output  1  one-cycle fill-complete pulse
fetched_address  output  32  line base of the line currently/last returned
prefetch  input  1  prefetch hint valid
prefetch_address  input  32  address to prefetch
prefetch_ready  output  1  hint accepted this cycle when prefetch also high
mem_address  output  32  line base to memory
mem_read  output  1  memory read request; held until mem_resp
mem_rdata  input  s_line  memory line data
mem_resp  input  1  memory read complete
pf_hit_count  output  cnt_w  demands served from buffer, saturating
pf_issue_count  output  cnt_w  prefetches sent to memory, saturating

Behaviour:
- Storage: buf_valid, buf_tag[31:s_offset], buf_data[s_line-1:0].
- Buffer hit = buf_valid and cache_pmem_address[31:s_offset] == buf_tag.
- Reset (rst low, immediate): state IDLE, buf_valid=0, all outputs 0 except prefetch_ready, all counters 0.
- prefetch_ready = (state==IDLE) and !cache_pmem_read, so it reads 1 in the first cycle after reset release.
- Reset mid-transaction: mem_read drops immediately and any in-flight fill is discarded. The memory side tolerates an abandoned request.
- State IDLE, priority demand > prefetch:
  - cache_pmem_read and buffer hit -> HIT_RESP.
  - cache_pmem_read and miss -> DEMAND; latch the line base.
  - else prefetch and accepted and the prefetch line is not already buffered -> PREFETCH; latch the line base; pf_issue_count++.
  - Accepted prefetch to an already-buffered line: dropped, no memory access.
- State HIT_RESP, 1 cycle:
  - cache_pmem_resp=1, cache_pmem_rdata=buf_data, fetched_address=buf_tag<<s_offset.
  - pf_hit_count++; buffer stays valid. -> DONE.
  - Hit latency: resp one cycle after cache_pmem_read is sampled.
- State DEMAND:
  - mem_read=1, mem_address=latched base, both stable until mem_resp.
  - On mem_resp, same cycle: cache_pmem_resp=1, cache_pmem_rdata=mem_rdata, fetched_address=base. -> DONE.
  - The buffer is not filled.
- State PREFETCH:
  - mem_read=1 with the latched base; not abortable.
  - On mem_resp: buf_data=mem_rdata, buf_tag=base tag, buf_valid=1. -> IDLE.
  - A demand arriving during PREFETCH waits. After the fill it is re-evaluated in IDLE, and a same-line demand hits the buffer.
- State DONE, 1 cycle:
  - Requests are ignored, prefetch_ready=0. -> IDLE.
  - This absorbs the cache dropping cache_pmem_read one cycle after resp, so no duplicate service.
- Outputs outside their response cycle:
  - cache_pmem_resp is 0.
  - cache_pmem_rdata holds its last value.
  - fetched_address holds until the next resp.
- Counters saturate at 2^cnt_w-1 and never wrap.
- Address arithmetic: only line-aligned bases appear on mem_address and fetched_address (low s_offset bits 0).

Test Plan:
- Reset: hold rst low 3 cycles mid-stream -> all outputs 0, counters 0. First cycle after release: prefetch_ready=1, mem_read=0.
- Demand miss cache_pmem_address=0x1000_0044, mem_resp 4 cycles later with rdata=0xA5..A5 -> mem_address=0x1000_0040; cache_pmem_resp in the mem_resp cycle with matching data; fetched_address=0x1000_0040; next cycle prefetch_ready=0 (DONE).
- Prefetch 0x1000_0060 accepted and filled, then demand 0x1000_0064 -> no mem_read; cache_pmem_resp 1 cycle later with buffered data; fetched_address=0x1000_0060; pf_hit_count=1, pf_issue_count=1.
- Prefetch 0x1000_0080 in flight, demand 0x1000_0080 arrives -> exactly one memory transaction; demand served from buffer after the fill; pf_hit_count increments.
- Same-cycle prefetch 0x2000 and demand 0x3000 in IDLE -> prefetch_ready=0, prefetch not accepted, mem_address=0x3000.
- Counter saturation with cnt_w forced to 2, 5 buffer hits -> pf_hit_count stops at 3.
